// File: rtl/oam_dma_if.sv
// ----------------------------------------------------------------------------
// oam_dma_if : snooped CPU bus plus DMA bus-initiator signals for oam_dma.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface oam_dma_if;
  logic        enable;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_rw_n;
  logic [7:0]  dma_data_in;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;
  logic        dma_rw_n;
  logic        done;

  modport master (
    input  enable, cpu_addr, cpu_data_out, cpu_rw_n, dma_data_in,
    output cpu_rdy, dma_active, dma_addr, dma_data_out, dma_rw_n, done
  );

  modport slave (
    output enable, cpu_addr, cpu_data_out, cpu_rw_n, dma_data_in,
    input  cpu_rdy, dma_active, dma_addr, dma_data_out, dma_rw_n, done
  );
endinterface

`default_nettype wire

// File: rtl/oam_dma.sv
// ----------------------------------------------------------------------------
// oam_dma : copies CPU page $XX00-$XXFF to PPU $2004 on a CPU write to $4014.
// Optional macro OAM_DMA_ALIGN_EN inserts a parity-alignment cycle. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module oam_dma (
  input  wire logic  clk,
  input  wire logic  rst,
  oam_dma_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  localparam logic [15:0] C_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] C_OAM_ADDR  = 16'h2004;

  logic [2:0] r_state;
  logic [7:0] r_page;
  logic [7:0] r_index;
  logic [7:0] r_data;
  logic       r_done;
  logic       w_trigger;

`ifdef OAM_DMA_ALIGN_EN
  logic       r_parity;
`endif

  assign w_trigger = !bus.cpu_rw_n && (bus.cpu_addr == C_TRIG_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_index <= 8'h00;
      r_data  <= 8'h00;
      r_done  <= 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      r_parity <= 1'b0;
`endif
    end else if (bus.enable) begin
`ifdef OAM_DMA_ALIGN_EN
      r_parity <= ~r_parity;
`endif
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_page  <= bus.cpu_data_out;
            r_index <= 8'h00;
            r_state <= S_HALT;
          end
        end
        S_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          // Parity flips on this edge: odd now means the read lands on even.
          r_state <= r_parity ? S_READ : S_ALIGN;
`else
          r_state <= S_READ;
`endif
        end
        S_ALIGN: r_state <= S_READ;
        S_READ: begin
          r_data  <= bus.dma_data_in;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_index <= r_index + 8'd1;
          if (r_index == 8'hFF) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode from state alone so reset takes effect immediately.
  always_comb begin
    bus.cpu_rdy      = 1'b1;
    bus.dma_active   = 1'b0;
    bus.dma_addr     = 16'h0000;
    bus.dma_data_out = 8'h00;
    bus.dma_rw_n     = 1'b1;
    case (r_state)
      S_HALT, S_ALIGN: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        bus.dma_addr   = {r_page, 8'h00};
      end
      S_READ: begin
        bus.cpu_rdy    = 1'b0;
        bus.dma_active = 1'b1;
        bus.dma_addr   = {r_page, r_index};
      end
      S_WRITE: begin
        bus.cpu_rdy      = 1'b0;
        bus.dma_active   = 1'b1;
        bus.dma_addr     = C_OAM_ADDR;
        bus.dma_data_out = r_data;
        bus.dma_rw_n     = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// ----------------------------------------------------------------------------
// tb_oam_dma : directed vector table plus multi-cycle sequences for oam_dma.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
  localparam int HALT_ODD = 514;
`else
  localparam int HALT_ODD = 513;
`endif
  localparam int HALT_EVEN = 513;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic par;

  oam_dma_if bus ();

  oam_dma dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Memory model: each byte is its address low byte xor $5A.
  assign bus.dma_data_in = bus.dma_addr[7:0] ^ 8'h5A;

  // Reference parity: toggles every enabled cycle, cleared by reset.
  always @(posedge clk or posedge rst) begin
    if (rst) par <= 1'b0;
    else if (bus.enable) par <= ~par;
  end

  int n_checks = 0;
  int n_fail   = 0;

  int          wr_cnt, halt_cnt, done_cnt;
  logic [7:0]  wr_data [0:299];
  logic [15:0] wr_rd_addr [0:299];
  logic [15:0] last_rd;

  always @(negedge clk) begin
    if (!rst && bus.enable) begin
      if (!bus.cpu_rdy) halt_cnt++;
      if (bus.done) done_cnt++;
      if (bus.dma_active && bus.dma_rw_n) last_rd = bus.dma_addr;
      if (bus.dma_active && !bus.dma_rw_n && bus.dma_addr == 16'h2004) begin
        if (wr_cnt < 300) begin
          wr_data[wr_cnt]    = bus.dma_data_out;
          wr_rd_addr[wr_cnt] = last_rd;
        end
        wr_cnt++;
      end
    end
  end

  typedef struct {
    logic        en;
    logic        rw_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        exp_rdy;
    logic        exp_act;
    logic [15:0] exp_addr;
    logic        exp_rw_n;
    logic [7:0]  exp_dout;
    logic        exp_done;
  } vec_t;

  vec_t vecs [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.enable       = 1'b1;
    bus.cpu_rw_n     = 1'b1;
    bus.cpu_addr     = 16'h0000;
    bus.cpu_data_out = 8'h00;
  endtask

  task automatic clear_counts();
    wr_cnt   = 0;
    halt_cnt = 0;
    done_cnt = 0;
    last_rd  = 16'h0000;
  endtask

  // Trigger on the edge whose pre-edge parity equals want_par.
  task automatic start_dma(input logic [7:0] pg, input logic want_par);
    set_idle();
    for (int c = 0; c < 4 && par !== want_par; c++) step();
    bus.cpu_rw_n     = 1'b0;
    bus.cpu_addr     = 16'h4014;
    bus.cpu_data_out = pg;
    step();
    set_idle();
  endtask

  task automatic wait_done();
    for (int c = 0; c < 1500 && done_cnt == 0; c++) step();
    repeat (3) step();
  endtask

  task automatic check_transfer(input logic [7:0] pg, input int exp_halt);
    int bad_d = 0;
    int bad_a = 0;
    for (int i = 0; i < 256; i++) begin
      if (wr_data[i] !== (8'(i) ^ 8'h5A)) bad_d++;
      if (wr_rd_addr[i] !== {pg, 8'(i)}) bad_a++;
    end
    check("write_count", 32'(wr_cnt), 32'd256);
    check("write_data_errors", 32'(bad_d), 32'd0);
    check("read_addr_errors", 32'(bad_a), 32'd0);
    check("halt_cycles", 32'(halt_cnt), 32'(exp_halt));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("cpu_rdy_after", 32'(bus.cpu_rdy), 32'd1);
    check("dma_active_after", 32'(bus.dma_active), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rdy"},    32'(bus.cpu_rdy),      32'd1);
    check({tag, "_dma_active"}, 32'(bus.dma_active),   32'd0);
    check({tag, "_dma_addr"},   32'(bus.dma_addr),     32'd0);
    check({tag, "_dma_rw_n"},   32'(bus.dma_rw_n),     32'd1);
    check({tag, "_dma_dout"},   32'(bus.dma_data_out), 32'd0);
    check({tag, "_done"},       32'(bus.done),         32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            en  rw_n  addr      wd     rdy act exp_addr  rw  dout   done
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h4014, 8'h02, 1'b0, 1'b1, 16'h0200, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 16'h4014, 8'h09, 1'b0, 1'b1, 16'h0200, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 16'h4014, 8'h09, 1'b0, 1'b1, 16'h0200, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h2004, 1'b0, 8'h5A, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0201, 1'b1, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h2004, 1'b0, 8'h5B, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h2004, 1'b0, 8'h5B, 1'b0};

    bus.enable       = 1'b0;
    bus.cpu_rw_n     = 1'b1;
    bus.cpu_addr     = 16'h0000;
    bus.cpu_data_out = 8'h00;
    clear_counts();

    // Reset state
    repeat (2) step();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Start of a page-$02 transfer, cycle by cycle, including a freeze
    // and an ignored retrigger.
    for (int i = 0; i < 8; i++) begin
      bus.enable       = vecs[i].en;
      bus.cpu_rw_n     = vecs[i].rw_n;
      bus.cpu_addr     = vecs[i].addr;
      bus.cpu_data_out = vecs[i].wdata;
      step();
      check($sformatf("vec%0d_cpu_rdy", i),    32'(bus.cpu_rdy),      32'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_dma_active", i), 32'(bus.dma_active),   32'(vecs[i].exp_act));
      check($sformatf("vec%0d_dma_addr", i),   32'(bus.dma_addr),     32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_dma_rw_n", i),   32'(bus.dma_rw_n),     32'(vecs[i].exp_rw_n));
      check($sformatf("vec%0d_dma_dout", i),   32'(bus.dma_data_out), 32'(vecs[i].exp_dout));
      check($sformatf("vec%0d_done", i),       32'(bus.done),         32'(vecs[i].exp_done));
    end
    set_idle();
    wait_done();
    check_transfer(8'h02, HALT_EVEN);

    // Opposite-parity trigger on page $07
    clear_counts();
    start_dma(8'h07, 1'b1);
    wait_done();
    check_transfer(8'h07, HALT_ODD);

    // Reset during write #100 aborts immediately
    clear_counts();
    start_dma(8'h05, 1'b0);
    for (int c = 0; c < 1000 && wr_cnt < 100; c++) begin
      @(negedge clk);
      #1;
    end
    check("abort_reached_write100", 32'(wr_cnt), 32'd100);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) step();
    check("abort_no_more_writes", 32'(wr_cnt), 32'd100);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
    clear_counts();
    start_dma(8'h05, 1'b0);
    wait_done();
    check_transfer(8'h05, HALT_EVEN);

    // Pause at index $80 with a $4014 write injected mid-transfer
    clear_counts();
    start_dma(8'h04, 1'b0);
    for (int c = 0; c < 1000 && wr_cnt < 128; c++) step();
    check("pause_at_index80", 32'(wr_cnt), 32'd128);
    bus.enable       = 1'b0;
    bus.cpu_rw_n     = 1'b0;
    bus.cpu_addr     = 16'h4014;
    bus.cpu_data_out = 8'h03;
    for (int c = 0; c < 7; c++) begin
      step();
      check("pause_cpu_halted", 32'(bus.cpu_rdy), 32'd0);
    end
    check("pause_addr_held", 32'(bus.dma_addr), 32'h0480);
    bus.enable = 1'b1;
    step();
    set_idle();
    wait_done();
    check_transfer(8'h04, HALT_EVEN);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 CLK  in  1  CPU clock; all state advances on rising edge when ENABLE=1.
REQ-002 RESET  in  1  reset, asynchronous, active-high.
REQ-003 ENABLE  in  1  clock enable; ENABLE=0 freezes all state and holds outputs.
REQ-004 CPU_ADDR  in  16  CPU address, snooped.
REQ-005 CPU_DATA_OUT  in  8  CPU write data, snooped.
REQ-006 CPU_RW_n  in  1  CPU direction; 1=read, 0=write.
REQ-007 DMA_DATA_IN  in  8  CPU data bus read value, valid at the CLK edge ending a DMA read cycle.
REQ-008 CPU_RDY  out  1  1=CPU may run, 0=CPU halted.
REQ-009 DMA_ACTIVE  out  1  1=bus mux selects DMA_ADDR/DMA_DATA_OUT/DMA_RW_n instead of CPU.
REQ-010 DMA_ADDR  out  16  DMA bus address.
REQ-011 DMA_DATA_OUT  out  8  DMA write data.
REQ-012 DMA_RW_n  out  1  DMA direction; 1=read, 0=write.
REQ-013 DONE  out  1  one-cycle pulse after final OAM write.

Function
REQ-014 The block SHALL be a bus initiator copying 256 bytes from CPU page $XX00-$XXFF to PPU $2004, triggered by a CPU write of $XX to $4014.
REQ-015 Trigger: in IDLE, ENABLE=1 and CPU_RW_n=0 and CPU_ADDR=16'h4014 SHALL latch CPU_DATA_OUT as page, clear byte index to 0, enter HALT next cycle.
REQ-016 States: IDLE, HALT, ALIGN, READ, WRITE.
REQ-017 A parity bit SHALL toggle every enabled cycle in all states; reset value 0.
REQ-018 HALT lasts exactly 1 cycle; exits to READ if parity in the next cycle is 0, else ALIGN (see REQ-030).
REQ-019 ALIGN lasts exactly 1 cycle, then READ.
REQ-020 READ: DMA_ADDR={page,index}, DMA_RW_n=1; DMA_DATA_IN latched into data register at cycle end; next state WRITE.
REQ-021 WRITE: DMA_ADDR=16'h2004, DMA_RW_n=0, DMA_DATA_OUT=latched byte; index increments (8-bit); index 8'hFF -> IDLE with DONE=1 for one cycle, else READ.
REQ-022 HALT/ALIGN: DMA_ADDR={page,8'h00}, DMA_RW_n=1 (dummy read).
REQ-023 CPU_RDY=0 and DMA_ACTIVE=1 in HALT, ALIGN, READ, WRITE; CPU_RDY=1, DMA_ACTIVE=0, DMA_RW_n=1 in IDLE.
REQ-024 Writes to $4014 while not IDLE SHALL be ignored (no page reload, no restart).
REQ-025 Total halt duration SHALL be 513 cycles (no ALIGN) or 514 cycles (ALIGN); exactly 256 WRITE cycles, addresses ascending from {page,00}.
REQ-026 ENABLE=0 mid-transfer SHALL pause without losing or duplicating any byte.
REQ-027 DONE SHALL never assert except on the cycle after the WRITE with index $FF.

Reset
REQ-028 RESET SHALL asynchronously force IDLE, parity=0, page=0, index=0, data register=0, CPU_RDY=1, DMA_ACTIVE=0, DMA_ADDR=0, DMA_DATA_OUT=0, DMA_RW_n=1, DONE=0.
REQ-029 RESET mid-transfer SHALL abort immediately, release CPU, and not assert DONE; no further writes to $2004.

Configuration
REQ-030 Macro OAM_DMA_ALIGN_EN: defined -> ALIGN inserted per parity (513/514 cycles); undefined -> ALIGN never entered, HALT always exits to READ (513 cycles), parity logic may be removed.

Verification
REQ-031 Reset, parity 0, CPU writes $02 to $4014 -> CPU_RDY low; reads $0200..$02FF each followed by write to $2004 with same byte; DONE pulse; CPU_RDY high; 513 or 514 cycles per OAM_DMA_ALIGN_EN/parity.
REQ-032 Trigger on opposite parity with OAM_DMA_ALIGN_EN -> halt length differs by 1 from REQ-031 (514 vs 513); without macro both 513.
REQ-033 Memory pattern byte=addr[7:0]^$5A on page $07 -> 256 $2004 writes carrying $5A,$5B,...,$A5 in order, no gaps or repeats.
REQ-034 Assert RESET at write #100 -> outputs at reset values same cycle, no DONE, no further $2004 writes; subsequent $4014 write restarts from index 0.
REQ-035 Drop ENABLE for 7 cycles at index $80 and inject CPU write $03 to $4014 during transfer -> transfer resumes, page unchanged, 256 correct writes total.
